// File: rtl/multicycle_control_fsm.sv
// Multi-cycle control unit: sequences FETCH/DECODE/EXECUTE/MEM/WB for the 16-bit datapath
// and drives its mux selects, ALU operation and write enables.
module multicycle_control_fsm #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        zero,
    input  logic        negative,
    input  logic        mem_ready,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [2:0]  alu_op,
    output logic        pc_src,
    output logic        pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        halted,
    output logic        bus_error,
    output logic        illegal_op
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

    localparam logic [3:0] OP_R    = 4'h0;
    localparam logic [3:0] OP_ADDI = 4'h1;
    localparam logic [3:0] OP_LW   = 4'h2;
    localparam logic [3:0] OP_SW   = 4'h3;
    localparam logic [3:0] OP_BEQ  = 4'h4;
    localparam logic [3:0] OP_BLT  = 4'h5;
    localparam logic [3:0] OP_JMP  = 4'h6;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALU_WB,
        S_MEM_RD,
        S_MEM_WB,
        S_MEM_WR,
        S_BRANCH,
        S_JUMP,
        S_HALT
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               bus_error_q, bus_error_d;
    logic               waiting;

    logic [3:0] opcode;
    logic [2:0] funct;
    logic       unused_instr;

    assign opcode       = instr[15:12];
    assign funct        = instr[2:0];
    assign unused_instr = &{1'b0, instr[11:3]};

    // State, wait counter and sticky bus error
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            cnt_q       <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_error_q <= bus_error_d;
        end
    end

    // Next state and decoded control outputs
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_error_d = bus_error_q;
        waiting     = 1'b0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        alu_op      = ALU_ADD;
        pc_src      = 1'b0;
        pc_write    = 1'b0;
        ir_write    = 1'b0;
        i_or_d      = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        mem_to_reg  = 1'b0;
        halted      = 1'b0;
        illegal_op  = 1'b0;
        bus_error   = bus_error_q;

        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    pc_write = 1'b1;
                    ir_write = 1'b1;
                    state_d  = S_DECODE;
                end else begin
                    waiting = 1'b1;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd2;
                case (opcode)
                    OP_R:                 state_d = S_EXEC_R;
                    OP_ADDI, OP_LW, OP_SW: state_d = S_EXEC_I;
                    OP_BEQ, OP_BLT:       state_d = S_BRANCH;
                    OP_JMP:               state_d = S_JUMP;
                    OP_HALT:              state_d = S_HALT;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_src_a = 2'd2;
                alu_op    = funct;
                state_d   = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd2;
                alu_src_b = 2'd2;
                case (opcode)
                    OP_LW:   state_d = S_MEM_RD;
                    OP_SW:   state_d = S_MEM_WR;
                    OP_ADDI: state_d = S_ALU_WB;
                    default: state_d = S_FETCH;
                endcase
            end
            S_ALU_WB: begin
                reg_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                i_or_d   = 1'b1;
                if (mem_ready) state_d = S_MEM_WB;
                else           waiting = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                i_or_d    = 1'b1;
                if (mem_ready) state_d = S_FETCH;
                else           waiting = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 2'd2;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                pc_write  = (opcode == OP_BEQ) ? zero : negative;
                state_d   = S_FETCH;
            end
            S_JUMP: begin
                alu_src_a = 2'd3;
                alu_src_b = 2'd2;
                pc_write  = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: state_d = S_FETCH;
        endcase

        // A late mem_ready on the last allowed cycle completes normally
        if (waiting) begin
            if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                bus_error_d = 1'b1;
                state_d     = S_HALT;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        if (state_d != state_q) cnt_d = '0;

        // Nothing may strobe while reset is held, even though the state already reads FETCH
        if (reset) begin
            alu_src_a  = 2'd0;
            alu_src_b  = 2'd0;
            alu_op     = ALU_ADD;
            pc_src     = 1'b0;
            pc_write   = 1'b0;
            ir_write   = 1'b0;
            i_or_d     = 1'b0;
            mem_read   = 1'b0;
            mem_write  = 1'b0;
            reg_write  = 1'b0;
            mem_to_reg = 1'b0;
            halted     = 1'b0;
            illegal_op = 1'b0;
            bus_error  = 1'b0;
        end
    end

endmodule
